// File: rtl/branch_target_predictor_pkg.sv
// Package for the IF-stage branch target predictor.
// Contents:
//   ctr_t            2-bit saturating direction counter (SNT/WNT/WT/ST)
//   IDX_BITS_DEF     default index width (2**IDX_BITS_DEF entries)
//   TAG_BITS_DEF     default tag width
//   seq_pc()         fall-through PC helper (pc + 4)
package branch_target_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,  // strongly not taken
      WNT = 2'b01,  // weakly not taken (reset value)
      WT  = 2'b10,  // weakly taken (value on allocation)
      ST  = 2'b11   // strongly taken
   } ctr_t;

   localparam int IDX_BITS_DEF = 6;
   localparam int TAG_BITS_DEF = 8;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Bundle between the pipeline (fetch/execute/hazard logic) and the branch
// target predictor.
//   fetch side  : pc_if -> pred_taken, pred_target (same-cycle lookup)
//   train side  : upd_en, ex_pc, ex_br, ex_target, ex_pred_taken, ex_pred_target
//   hazard side : mispredict, correct_pc
//   statistics  : br_cnt, miss_cnt
//   debug       : dbg_hit, dbg_ctr (lookup hit and counter state of the entry
//                 indexed by pc_if)
// Handshake: upd_en is a valid-only qualifier for the whole ex_* group. The
// predictor has no backpressure: every cycle with upd_en=1 is one training
// transfer, consumed on that clock edge. The fetch lookup carries no valid and
// is answered combinationally every cycle.
// Modports: master = pipeline side, slave = predictor.
interface branch_target_predictor_if;
   import branch_target_predictor_pkg::*;

   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_target;

   logic        upd_en;
   logic [31:0] ex_pc;
   logic        ex_br;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;

   logic        mispredict;
   logic [31:0] correct_pc;

   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;

   logic        dbg_hit;
   ctr_t        dbg_ctr;

   modport master (
      output pc_if, upd_en, ex_pc, ex_br, ex_target, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, mispredict, correct_pc, br_cnt, miss_cnt,
             dbg_hit, dbg_ctr
   );

   modport slave (
      input  pc_if, upd_en, ex_pc, ex_br, ex_target, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, mispredict, correct_pc, br_cnt, miss_cnt,
             dbg_hit, dbg_ctr
   );

endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// Next-state function of the 2-bit saturating direction counter.
// Ports:
//   ctr      in   current counter state
//   taken    in   actual branch outcome
//   ctr_next out  SNT<->WNT<->WT<->ST, saturating at both ends (no wrap)
module branch_target_predictor_sat_counter2
   import branch_target_predictor_pkg::*;
(
   input  ctr_t ctr,
   input  logic taken,
   output ctr_t ctr_next
);

   always_comb begin
      ctr_next = ctr;
      case (ctr)
         SNT:     ctr_next = taken ? WNT : SNT;
         WNT:     ctr_next = taken ? WT  : SNT;
         WT:      ctr_next = taken ? ST  : WNT;
         ST:      ctr_next = taken ? ST  : WT;
         default: ctr_next = WNT;
      endcase
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk   core clock, all state updates on posedge
//   rst   synchronous active-high reset; clears the table and statistics
//   bus   branch_target_predictor_if.slave (lookup, training, mispredict,
//         statistics and debug signals)
// Lookup uses pc_if[IDX_BITS+1:2] as index and the next TAG_BITS bits as tag.
// Training from EX writes on the clock edge, so a lookup of the same index in
// the same cycle sees the pre-update entry.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int IDX_BITS = IDX_BITS_DEF,
   parameter int TAG_BITS = TAG_BITS_DEF
) (
   input logic                      clk,
   input logic                      rst,
   branch_target_predictor_if.slave bus
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_LSB = IDX_BITS + 2;
   localparam int TAG_MSB = IDX_BITS + TAG_BITS + 1;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   ctr_t                ctr_q    [ENTRIES];

   logic [31:0] br_cnt_q;
   logic [31:0] miss_cnt_q;

   // ---------------- fetch-side lookup ----------------
   logic [IDX_BITS-1:0] idx_if;
   logic [TAG_BITS-1:0] tag_if;
   logic                hit_if;
   ctr_t                ctr_if;

   assign idx_if = bus.pc_if[IDX_BITS+1:2];
   assign tag_if = bus.pc_if[TAG_MSB:TAG_LSB];
   assign ctr_if = ctr_q[idx_if];
   assign hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);

   // Only the MSB of the counter matters for direction (WT/ST predict taken).
   assign bus.pred_taken  = hit_if && ctr_if[1];
   assign bus.pred_target = bus.pred_taken ? target_q[idx_if] : seq_pc(bus.pc_if);
   assign bus.dbg_hit     = hit_if;
   assign bus.dbg_ctr     = ctr_if;

   // ---------------- execute-side training ----------------
   logic [IDX_BITS-1:0] idx_ex;
   logic [TAG_BITS-1:0] tag_ex;
   logic                hit_ex;
   ctr_t                ctr_ex_next;

   assign idx_ex = bus.ex_pc[IDX_BITS+1:2];
   assign tag_ex = bus.ex_pc[TAG_MSB:TAG_LSB];
   assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

   branch_target_predictor_sat_counter2 u_sat_counter2 (
      .ctr      (ctr_q[idx_ex]),
      .taken    (bus.ex_br),
      .ctr_next (ctr_ex_next)
   );

   // A taken branch with the right direction but a stale target still flushes.
   assign bus.mispredict = bus.upd_en &&
                           ((bus.ex_pred_taken != bus.ex_br) ||
                            (bus.ex_br && (bus.ex_pred_target != bus.ex_target)));
   assign bus.correct_pc = bus.ex_br ? bus.ex_target : seq_pc(bus.ex_pc);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= WNT;
         end
      end else if (bus.upd_en) begin
         if (hit_ex) begin
            ctr_q[idx_ex] <= ctr_ex_next;
            if (bus.ex_br) begin
               target_q[idx_ex] <= bus.ex_target;
            end
         end else if (bus.ex_br) begin
            // Allocate or evict the aliasing entry; new entries start weakly taken.
            valid_q[idx_ex]  <= 1'b1;
            tag_q[idx_ex]    <= tag_ex;
            target_q[idx_ex] <= bus.ex_target;
            ctr_q[idx_ex]    <= WT;
         end
      end
   end

   // ---------------- statistics (free-running, wrap at 2**32) ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         br_cnt_q   <= br_cnt_q   + {31'b0, bus.upd_en};
         miss_cnt_q <= miss_cnt_q + {31'b0, bus.mispredict};
      end
   end

   assign bus.br_cnt   = br_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;

   // Address bits outside index/tag do not take part in prediction.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.pc_if[31:TAG_MSB+1], bus.pc_if[1:0],
                             bus.ex_pc[31:TAG_MSB+1], bus.ex_pc[1:0]};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor.
// A driver applies one cycle of stimulus at each negedge and pushes the
// reference model's expected outputs into exp_q; a monitor pops and compares
// shortly after, before the next posedge. The model is a plain per-index
// table with integer counters updated with min/max arithmetic.
module tb_branch_target_predictor;
   import branch_target_predictor_pkg::*;

   localparam int IDX_BITS = 6;
   localparam int TAG_BITS = 8;
   localparam int ENTRIES  = 1 << IDX_BITS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_target_predictor_if bus ();

   branch_target_predictor #(
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0] pc_if;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic        mispredict;
      logic [31:0] correct_pc;
      logic [31:0] br_cnt;
      logic [31:0] miss_cnt;
      logic [1:0]  ctr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // ---------------- reference model ----------------
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   logic [31:0] m_br_cnt;
   logic [31:0] m_miss_cnt;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit model_taken(input logic [31:0] pc);
      return model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   function automatic logic [31:0] model_target(input logic [31:0] pc);
      return model_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = '0;
         m_ctr[i]    = 1;
      end
      m_br_cnt   = '0;
      m_miss_cnt = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic [31:0] pc_if, input logic upd,
                        input logic [31:0] ex_pc, input logic br,
                        input logic [31:0] tgt, input logic ptk,
                        input logic [31:0] ptgt);
      exp_t        e;
      bit          mp;
      int unsigned j;
      @(negedge clk);
      rst                = 1'b0;
      bus.pc_if          = pc_if;
      bus.upd_en         = upd;
      bus.ex_pc          = ex_pc;
      bus.ex_br          = br;
      bus.ex_target      = tgt;
      bus.ex_pred_taken  = ptk;
      bus.ex_pred_target = ptgt;

      mp            = upd && ((ptk != br) || (br && (ptgt != tgt)));
      e.pc_if       = pc_if;
      e.pred_taken  = model_taken(pc_if);
      e.pred_target = model_target(pc_if);
      e.mispredict  = mp;
      e.correct_pc  = br ? tgt : ex_pc + 32'd4;
      e.br_cnt      = m_br_cnt;
      e.miss_cnt    = m_miss_cnt;
      e.ctr         = 2'(m_ctr[idx_of(pc_if)]);
      exp_q.push_back(e);

      // Training becomes visible to the next cycle's expectation.
      if (upd) begin
         m_br_cnt = m_br_cnt + 32'd1;
         if (mp) m_miss_cnt = m_miss_cnt + 32'd1;
         j = idx_of(ex_pc);
         if (model_hit(ex_pc)) begin
            m_ctr[j] = br ? ((m_ctr[j] < 3) ? m_ctr[j] + 1 : 3)
                          : ((m_ctr[j] > 0) ? m_ctr[j] - 1 : 0);
            if (br) m_target[j] = tgt;
         end else if (br) begin
            m_valid[j]  = 1'b1;
            m_tag[j]    = tag_of(ex_pc);
            m_target[j] = tgt;
            m_ctr[j]    = 2;
         end
      end
   endtask

   task automatic look(input logic [31:0] pc_if);
      cycle(pc_if, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // One reset edge with a taken update presented, which must be ignored.
   task automatic do_reset();
      @(negedge clk);
      rst                = 1'b1;
      bus.upd_en         = 1'b1;
      bus.ex_pc          = 32'h100;
      bus.ex_br          = 1'b1;
      bus.ex_target      = 32'h900;
      bus.ex_pred_taken  = 1'b0;
      bus.ex_pred_target = 32'h104;
      model_reset();
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 2) << 8) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      return pc;
   endfunction

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp, input logic [31:0] pc);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s pc_if=%h got=%h expected=%h t=%0t", name, pc, act, exp, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pred_taken",  {31'b0, bus.pred_taken}, {31'b0, e.pred_taken}, e.pc_if);
            chk("pred_target", bus.pred_target,         e.pred_target,         e.pc_if);
            chk("mispredict",  {31'b0, bus.mispredict}, {31'b0, e.mispredict}, e.pc_if);
            chk("correct_pc",  bus.correct_pc,          e.correct_pc,          e.pc_if);
            chk("br_cnt",      bus.br_cnt,              e.br_cnt,              e.pc_if);
            chk("miss_cnt",    bus.miss_cnt,            e.miss_cnt,            e.pc_if);
            chk("ctr",         {30'b0, bus.dbg_ctr},    {30'b0, e.ctr},        e.pc_if);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] pc, xpc, tgt, ptgt;
      logic        upd, br, ptk;

      bus.pc_if = 32'h100; bus.upd_en = 1'b0; bus.ex_pc = '0; bus.ex_br = 1'b0;
      bus.ex_target = '0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
      do_reset();

      // Reset state.
      look(32'h100);

      // First taken update allocates; next cycle predicts taken to 0x80.
      cycle(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      look(32'h100);

      // Not-taken training saturates at SNT; then two taken steps back to WT.
      cycle(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      cycle(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      cycle(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      cycle(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      cycle(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      cycle(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      look(32'h100);

      // Alias at the same index with a different tag replaces the entry.
      cycle(32'h100, 1'b1, 32'h100 + (4 << IDX_BITS), 1'b1, 32'h444, 1'b0, 32'h204);
      look(32'h100);
      look(32'h100 + (4 << IDX_BITS));

      // Taken branch predicted taken but to a stale target.
      cycle(32'h200, 1'b1, 32'h200, 1'b1, 32'h555, 1'b1, 32'h444);
      look(32'h200);

      // Same-cycle lookup/update after reset: old contents this cycle, new next.
      do_reset();
      cycle(32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
      look(32'h200);

      // br_cnt wrap from all-ones to zero.
      look(32'h200);
      @(posedge clk);
      #1;
      force dut.br_cnt_q = 32'hFFFF_FFFF;
      m_br_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.br_cnt_q;
      cycle(32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
      look(32'h200);

      // Mid-stream reset discards trained entries.
      cycle(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      look(32'h100);
      do_reset();
      look(32'h100);
      look(32'h200);

      // Randomized traffic over a small address pool to force hits and aliases.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            pc  = rand_pc();
            xpc = rand_pc();
            upd = ($urandom_range(0, 9) < 7);
            br  = $urandom_range(0, 1);
            tgt = {$urandom_range(0, 15), 2'b00} << 4;
            if ($urandom_range(0, 1) == 1) begin
               ptk  = model_taken(xpc);
               ptgt = model_target(xpc);
            end else begin
               ptk  = $urandom_range(0, 1);
               ptgt = ptk ? tgt : xpc + 32'd4;
            end
            cycle(pc, upd, xpc, br, tgt, ptk, ptgt);
         end
      end

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain pending=%0d", exp_q.size());
      end
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
